// File: rtl/regfile_scoreboard.sv
// Parametrised decode-stage register file with write-to-read bypass and a
// per-register busy scoreboard for hazard detection.
module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              MarkBusy,
  input  logic [ADDR_W-1:0] BusyRegister,
  output logic              Busy1,
  output logic              Busy2,
  output logic              AnyBusy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic valid_rd1;
  logic valid_rd2;
  logic valid_wr;
  logic valid_mark;
  logic hit1;
  logic hit2;

  // Indices past DEPTH are representable when DEPTH is not a power of two.
  function automatic logic is_valid(input logic [ADDR_W-1:0] idx);
    return (int'(idx) < DEPTH) && (int'(idx) != ZERO_REG);
  endfunction

  assign valid_rd1  = is_valid(ReadRegister1);
  assign valid_rd2  = is_valid(ReadRegister2);
  assign valid_wr   = is_valid(WriteRegister);
  assign valid_mark = is_valid(BusyRegister);

  assign hit1 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister1);
  assign hit2 = (BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    Busy1     = 1'b0;
    Busy2     = 1'b0;
    if (valid_rd1) begin
      ReadData1 = hit1 ? WriteData : mem[ReadRegister1];
      Busy1     = busy[ReadRegister1] && !hit1;
    end
    if (valid_rd2) begin
      ReadData2 = hit2 ? WriteData : mem[ReadRegister2];
      Busy2     = busy[ReadRegister2] && !hit2;
    end
  end

  assign AnyBusy = |busy;

  // Mark is applied after the write-clear so a newly issued producer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (RegWrite && valid_wr) begin
        mem[WriteRegister]  <= WriteData;
        busy[WriteRegister] <= 1'b0;
      end
      if (MarkBusy && valid_mark) begin
        busy[BusyRegister] <= 1'b1;
      end
    end
  end

endmodule
